// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: opcodes of interest, fetch FSM states and the
// control-flow decode used to decide when fetch must stop.
package riscv_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] OP_NOP    = 32'h00000013;

    typedef enum logic [0:0] {
        StFetch,
        StWaitRedirect
    } fetch_state_e;

    // Jumps only stop fetch when the core is built to wait on them.
    function automatic logic is_ctrl_op(logic [6:0] opcode, logic stop_jump);
        is_ctrl_op = (opcode == OP_BRANCH) ||
                     (stop_jump && ((opcode == OP_JAL) || (opcode == OP_JALR)));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode; the head
// entry is presented combinationally and flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential-PC fetch unit: issues requests to a 1-cycle instruction memory,
// queues responses for decode and parks on control flow until redirected.
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter bit              STOP_JUMP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            stalled
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned OccW = CntW + 1;
    localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, inflight_pc_q;
    logic              inflight_q, inflight_d;
    logic [CntW-1:0]   count;
    logic [OccW-1:0]   occupancy;
    logic [2*XLEN-1:0] head, shown, head_last_q;
    logic              issue, push, pop, rsp_ctrl;

    // Reserve a slot for the outstanding response so a push can never overflow.
    assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
    assign issue     = rst_n && (state_q == StFetch) && !redirect && (occupancy < DepthOcc);
    assign rsp_ctrl  = inflight_q && is_ctrl_op(imem_rdata[6:0], STOP_JUMP);
    assign push      = inflight_q && !redirect;
    assign pop       = out_valid && out_ready;

    // A request issued alongside a control-flow response is squashed here.
    assign inflight_d = issue && !rsp_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = StFetch;
        end else if ((state_q == StFetch) && rsp_ctrl) begin
            state_d = StWaitRedirect;
        end
    end

    always_comb begin
        stalled   = (state_q == StWaitRedirect);
        imem_req  = issue;
        imem_addr = pc_q;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~XLEN'(32'd3);
        end else if (issue) begin
            pc_d = pc_q + XLEN'(32'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_last_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            head_last_q <= shown;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2 * XLEN)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(redirect),
        .wdata({inflight_pc_q, imem_rdata}),
        .head (head),
        .count(count)
    );

    // When the queue drains the last presented entry stays on the outputs.
    assign out_valid = (count != '0);
    assign shown     = out_valid ? head : head_last_q;
    assign out_pc    = shown[2*XLEN-1:XLEN];
    assign out_instr = shown[XLEN-1:0];

endmodule
